kd_tree_root_ctrl: RTL and testbench

//  Initiator for the kd-tree node command protocol. Drives the top port of the root node.

---
 rtl/kd_tree_root_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_kd_tree_root_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_root_ctrl.sv
// -----------------------------------------------------------------------------
// kd_tree_root_ctrl
//   Initiator for the kd-tree node command protocol. Drives the top port of
//   the root node through rst -> center_fill -> configure_sort_axis ->
//   start_sorting, then waits until the tree has been quiet long enough to be
//   considered sorted. Buffers the initial centers written by the host and
//   reports done / error and the root node's final center.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   load_valid/data    host center write; load_ready says the buffer accepts it
//   start              one-cycle pulse that begins a run (needs >= 1 center)
//   busy               run in progress (RST..SORT)
//   done / error       run result, held until the next accepted start
//   phase              current FSM state encoding
//   root_center        root node center captured when the sort went stable
//   command_to_root    command to root node command_from_top
//   data_to_root       data to root node data_from_top
//   command_from_root  root node command_to_top
//   data_from_root     root node data_to_top
// -----------------------------------------------------------------------------
module kd_tree_root_ctrl #(
  parameter int DATA_W        = 24,
  parameter int CMD_W         = 5,
  parameter int N_CENTERS     = 8,
  parameter int TIMEOUT       = 1023,
  parameter int STABLE_CYCLES = 4,
  parameter int SORT_AXIS     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        phase,
  output logic [DATA_W-1:0] root_center,
  output logic [CMD_W-1:0]  command_to_root,
  output logic [DATA_W-1:0] data_to_root,
  input  logic [CMD_W-1:0]  command_from_root,
  input  logic [DATA_W-1:0] data_from_root
);

  localparam int CW = $clog2(N_CENTERS + 1);
  localparam int IW = (N_CENTERS > 1) ? $clog2(N_CENTERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [CMD_W-1:0] CMD_NOP          = CMD_W'(5'h00);
  localparam logic [CMD_W-1:0] CMD_RST          = CMD_W'(5'h1f);
  localparam logic [CMD_W-1:0] CMD_RST_DONE     = CMD_W'(5'h1e);
  localparam logic [CMD_W-1:0] CMD_FILL         = CMD_W'(5'h01);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE    = CMD_W'(5'h05);
  localparam logic [CMD_W-1:0] CMD_CFG_AXIS     = CMD_W'(5'h02);
  localparam logic [CMD_W-1:0] CMD_CFG_DONE     = CMD_W'(5'h07);
  localparam logic [CMD_W-1:0] CMD_START_SORT   = CMD_W'(5'h09);
  localparam logic [CMD_W-1:0] CMD_READY_SORT   = CMD_W'(5'h0a);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_CFG  = 3'd3;
  localparam logic [2:0] S_SORT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]        state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [CW-1:0]     rd_ptr, rd_ptr_n;
  logic [TW-1:0]     timer, timer_n, timer_inc;
  logic [SW-1:0]     stable_cnt, stable_n, stable_inc;
  logic              sort_seen, sort_seen_n;
  logic              done_n, error_n, busy_n, load_ready_n;
  logic [DATA_W-1:0] root_n, data_n;
  logic [CMD_W-1:0]  cmd_n;
  logic              wr_en;
  logic              in_run;
  logic              quiet;

  logic [DATA_W-1:0] center_buf [N_CENTERS];

  assign phase = state;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    count_n     = count;
    rd_ptr_n    = rd_ptr;
    timer_n     = timer;
    stable_n    = stable_cnt;
    sort_seen_n = sort_seen;
    done_n      = done;
    error_n     = error;
    root_n      = root_center;
    wr_en       = 1'b0;
    timer_inc   = timer + TW'(1);
    stable_inc  = stable_cnt + SW'(1);
    quiet       = (command_from_root == CMD_NOP) ||
                  (command_from_root == CMD_READY_SORT);
    in_run      = (state == S_RST) || (state == S_FILL) ||
                  (state == S_CFG) || (state == S_SORT);

    case (state)
      S_IDLE: begin
        wr_en = load_valid && load_ready;
        if (wr_en) count_n = count + CW'(1);
        if (start && (count != '0)) begin
          state_n = S_RST;
          done_n  = 1'b0;
          error_n = 1'b0;
        end
      end
      S_RST: begin
        if (command_from_root == CMD_RST_DONE) begin
          state_n  = S_FILL;
          rd_ptr_n = '0;
        end
      end
      S_FILL: begin
        if (command_from_root == CMD_FILL_DONE) begin
          state_n  = S_CFG;
          rd_ptr_n = '0;
        end else if (rd_ptr < count - CW'(1)) begin
          // Once the buffer is exhausted the last center keeps repeating.
          rd_ptr_n = rd_ptr + CW'(1);
        end
      end
      S_CFG: begin
        if (command_from_root == CMD_CFG_DONE) begin
          state_n     = S_SORT;
          sort_seen_n = 1'b0;
          stable_n    = '0;
        end
      end
      S_SORT: begin
        if (!sort_seen) begin
          if (command_from_root == CMD_READY_SORT) begin
            sort_seen_n = 1'b1;
            stable_n    = '0;
          end
        end else if (quiet) begin
          if (stable_inc == SW'(STABLE_CYCLES)) begin
            root_n  = data_from_root;
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            stable_n = stable_inc;
          end
        end else begin
          // Any activity in the tree restarts the quiet-window count.
          stable_n = '0;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Phase watchdog: restarts on every state change; a progress transition
    // in the same cycle as expiry wins.
    if (state_n != state) begin
      timer_n = '0;
    end else if (in_run) begin
      if (timer_inc == TW'(TIMEOUT)) begin
        state_n = S_ERR;
        error_n = 1'b1;
        timer_n = '0;
      end else begin
        timer_n = timer_inc;
      end
    end

    // Outputs are decoded from the next state and registered below.
    busy_n       = (state_n == S_RST) || (state_n == S_FILL) ||
                   (state_n == S_CFG) || (state_n == S_SORT);
    load_ready_n = (state_n == S_IDLE) && (count_n < CW'(N_CENTERS));
    cmd_n        = CMD_NOP;
    data_n       = '0;
    case (state_n)
      S_RST:  cmd_n = CMD_RST;
      S_FILL: begin
        cmd_n  = CMD_FILL;
        data_n = center_buf[rd_ptr_n[IW-1:0]];
      end
      S_CFG: begin
        cmd_n  = CMD_CFG_AXIS;
        data_n = DATA_W'(SORT_AXIS);
      end
      S_SORT: begin
        if (!sort_seen_n) begin
          cmd_n  = CMD_START_SORT;
          data_n = DATA_W'(SORT_AXIS);
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      count           <= '0;
      rd_ptr          <= '0;
      timer           <= '0;
      stable_cnt      <= '0;
      sort_seen       <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      busy            <= 1'b0;
      load_ready      <= 1'b0;
      root_center     <= '0;
      command_to_root <= CMD_NOP;
      data_to_root    <= '0;
    end else begin
      state           <= state_n;
      count           <= count_n;
      rd_ptr          <= rd_ptr_n;
      timer           <= timer_n;
      stable_cnt      <= stable_n;
      sort_seen       <= sort_seen_n;
      done            <= done_n;
      error           <= error_n;
      busy            <= busy_n;
      load_ready      <= load_ready_n;
      root_center     <= root_n;
      command_to_root <= cmd_n;
      data_to_root    <= data_n;
    end
  end

  // NOTE: the center buffer has no reset; count gates every read, so stale
  // contents are never observed and the array can map to plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) center_buf[count[IW-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kd_tree_root_ctrl
//   Directed bench for kd_tree_root_ctrl with default parameters. The root
//   node is played by hand-driven responses; each step drives inputs #1 after
//   a rising edge and checks registered outputs at the same point.
// -----------------------------------------------------------------------------
module tb_kd_tree_root_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [23:0] load_data;
  logic        load_ready;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  phase;
  logic [23:0] root_center;
  logic [4:0]  command_to_root;
  logic [23:0] data_to_root;
  logic [4:0]  command_from_root;
  logic [23:0] data_from_root;

  int n_cmp = 0;
  int n_mis = 0;

  kd_tree_root_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_valid        (load_valid),
    .load_data         (load_data),
    .load_ready        (load_ready),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .phase             (phase),
    .root_center       (root_center),
    .command_to_root   (command_to_root),
    .data_to_root      (data_to_root),
    .command_from_root (command_from_root),
    .data_from_root    (data_from_root)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [23:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    start = 1'b0;
    command_from_root = 5'h00;
    data_from_root = '0;

    // ---- reset state ----
    #3;
    check("rst_cmd", 32'(command_to_root), 32'h00);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_done_err", 32'({done, error}), 32'd0);
    #4 rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(load_ready), 32'd1);

    // ---- start with empty buffer is ignored ----
    pulse_start();
    check("empty_start_phase", 32'(phase), 32'd0);
    check("empty_start_busy", 32'(busy), 32'd0);

    // ---- run 1: three centers, full protocol ----
    load(24'h0A0B0C);
    load(24'h101010);
    load(24'h202020);
    pulse_start();
    check("r1_rst_phase", 32'(phase), 32'd1);
    check("r1_rst_cmd1", 32'(command_to_root), 32'h1f);
    check("r1_busy", 32'(busy), 32'd1);
    check("r1_rst_data", 32'(data_to_root), 32'h0);
    check("r1_ready_busy", 32'(load_ready), 32'd0);
    tick();
    check("r1_rst_cmd2", 32'(command_to_root), 32'h1f);
    command_from_root = 5'h1e;
    tick();
    command_from_root = 5'h00;
    check("r1_fill_phase", 32'(phase), 32'd2);
    check("r1_fill_cmd", 32'(command_to_root), 32'h01);
    check("r1_fill_d0", 32'(data_to_root), 32'h0A0B0C);
    tick();
    check("r1_fill_d1", 32'(data_to_root), 32'h101010);
    tick();
    check("r1_fill_d2", 32'(data_to_root), 32'h202020);
    tick();
    check("r1_fill_d3", 32'(data_to_root), 32'h202020);
    command_from_root = 5'h05;
    tick();
    command_from_root = 5'h00;
    check("r1_cfg_phase", 32'(phase), 32'd3);
    check("r1_cfg_cmd", 32'(command_to_root), 32'h02);
    check("r1_cfg_data", 32'(data_to_root), 32'h0);
    command_from_root = 5'h07;
    tick();
    command_from_root = 5'h00;
    check("r1_sort_phase", 32'(phase), 32'd4);
    check("r1_sort_cmd", 32'(command_to_root), 32'h09);
    tick();
    check("r1_sort_cmd_hold", 32'(command_to_root), 32'h09);
    command_from_root = 5'h0a;
    tick();
    check("r1_sort_nop", 32'(command_to_root), 32'h00);
    // busy x3; start pulsed during SORT must be ignored
    command_from_root = 5'h08;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r1_start_in_sort", 32'(phase), 32'd4);
    tick();
    tick();
    check("r1_busy_resp", 32'(phase), 32'd4);
    command_from_root = 5'h00;
    data_from_root = 24'h112233;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r1_quiet_wait", 32'(phase), 32'd4);
    end
    tick();
    command_from_root = 5'h00;
    data_from_root = '0;
    check("r1_done_phase", 32'(phase), 32'd5);
    check("r1_done", 32'(done), 32'd1);
    check("r1_done_busy", 32'(busy), 32'd0);
    check("r1_root_center", 32'(root_center), 32'h112233);
    check("r1_done_cmd", 32'(command_to_root), 32'h00);
    tick();
    check("r1_idle_phase", 32'(phase), 32'd0);
    check("r1_done_held", 32'(done), 32'd1);

    // ---- run 2: root never answers rst_done -> timeout ----
    pulse_start();
    check("to_done_cleared", 32'(done), 32'd0);
    check("to_rst_phase", 32'(phase), 32'd1);
    repeat (1022) tick();
    check("to_still_rst", 32'(phase), 32'd1);
    check("to_still_rst_cmd", 32'(command_to_root), 32'h1f);
    tick();
    check("to_err_phase", 32'(phase), 32'd6);
    check("to_error", 32'(error), 32'd1);
    check("to_err_cmd", 32'(command_to_root), 32'h00);
    check("to_err_busy", 32'(busy), 32'd0);
    tick();
    check("to_idle_phase", 32'(phase), 32'd0);
    check("to_error_held", 32'(error), 32'd1);

    // ---- run 3: reset asserted mid-FILL ----
    pulse_start();
    check("mr_error_cleared", 32'(error), 32'd0);
    command_from_root = 5'h1e;
    tick();
    command_from_root = 5'h00;
    check("mr_fill_phase", 32'(phase), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mr_cmd0", 32'(command_to_root), 32'h00);
    check("mr_data0", 32'(data_to_root), 32'h0);
    check("mr_phase0", 32'(phase), 32'd0);
    check("mr_busy0", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mr_ready", 32'(load_ready), 32'd1);
    pulse_start();
    check("mr_empty_start", 32'(phase), 32'd0);
    load(24'h555555);
    load(24'h666666);
    pulse_start();
    check("mr_rerun_phase", 32'(phase), 32'd1);
    command_from_root = 5'h1e;
    tick();
    command_from_root = 5'h00;
    check("mr_fill_d0", 32'(data_to_root), 32'h555555);
    tick();
    check("mr_fill_d1", 32'(data_to_root), 32'h666666);
    tick();
    check("mr_fill_d2", 32'(data_to_root), 32'h666666);
    command_from_root = 5'h05;
    tick();
    command_from_root = 5'h07;
    tick();
    command_from_root = 5'h0a;
    tick();
    command_from_root = 5'h00;
    data_from_root = 24'hABCDEF;
    repeat (4) tick();
    data_from_root = '0;
    check("mr_done_phase", 32'(phase), 32'd5);
    check("mr_root_center", 32'(root_center), 32'hABCDEF);
    tick();

    // ---- run 4: overfill the buffer ----
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1;
      load_data = 24'(i + 1);
      check("of_ready", 32'(load_ready), (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    load_valid = 1'b0;
    check("of_ready_full", 32'(load_ready), 32'd0);
    pulse_start();
    command_from_root = 5'h1e;
    tick();
    command_from_root = 5'h00;
    for (int i = 0; i < 9; i++) begin
      check("of_fill_data", 32'(data_to_root), (i < 8) ? 32'(i + 1) : 32'd8);
      tick();
    end
    command_from_root = 5'h05;
    tick();
    command_from_root = 5'h07;
    tick();
    command_from_root = 5'h0a;
    tick();
    command_from_root = 5'h00;
    data_from_root = 24'h000777;
    repeat (4) tick();
    check("of_done", 32'(done), 32'd1);
    check("of_root_center", 32'(root_center), 32'h000777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
